// File: rtl/line_buffer_3row.sv
// Raster-to-column window generator: buffers the two previous rows and emits
// the vertically aligned 3-pixel column {row y, row y-1, row y-2} per pixel.
module line_buffer_3row #(
    parameter int PIXEL_WIDTH  = 14,
    parameter int IMAGE_WIDTH  = 128,
    parameter int IMAGE_HEIGHT = 128,
    parameter int LINE_NUM     = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [PIXEL_WIDTH-1:0]          din,
    input  logic                            din_valid,
    input  logic                            sof,
    output logic [PIXEL_WIDTH*LINE_NUM-1:0] data_out,
    output logic                            dout_valid,
    output logic                            dout_last
);

    // Number of bits needed to hold the value (minimum 1).
    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned bits;
        bits = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((value >> i) != 0) bits = i + 1;
        end
        return (bits == 0) ? 1 : bits;
    endfunction

    localparam int unsigned COL_W = clogb2(IMAGE_WIDTH - 1);
    localparam int unsigned ROW_W = clogb2(IMAGE_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);
    localparam logic [ROW_W-1:0] ROW_FIRST_OUT = ROW_W'(2);

    if (LINE_NUM != 3) begin : g_line_num_check
        $error("line_buffer_3row: LINE_NUM must be 3");
    end

    logic [COL_W-1:0]                col_q, col_d;
    logic [ROW_W-1:0]                row_q, row_d;
    logic [PIXEL_WIDTH*LINE_NUM-1:0] data_out_q, data_out_d;
    logic                            dout_valid_q, dout_valid_d;
    logic                            dout_last_q, dout_last_d;

    logic [PIXEL_WIDTH-1:0] line0_q [IMAGE_WIDTH];
    logic [PIXEL_WIDTH-1:0] line1_q [IMAGE_WIDTH];

    logic [COL_W-1:0]       eff_col;
    logic [ROW_W-1:0]       eff_row;
    logic [PIXEL_WIDTH-1:0] rd_line0;
    logic [PIXEL_WIDTH-1:0] rd_line1;

    // sof overrides the tracked position so the pixel lands at (0,0).
    always_comb begin
        eff_col  = sof ? '0 : col_q;
        eff_row  = sof ? '0 : row_q;
        rd_line0 = line0_q[eff_col];
        rd_line1 = line1_q[eff_col];
    end

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        data_out_d   = data_out_q;
        dout_valid_d = 1'b0;
        dout_last_d  = 1'b0;
        if (din_valid) begin
            data_out_d   = {din, rd_line1, rd_line0};
            dout_valid_d = (eff_row >= ROW_FIRST_OUT);
            dout_last_d  = (eff_row >= ROW_FIRST_OUT) && (eff_col == COL_LAST);
            if (sof) begin
                col_d = COL_W'(1);
                row_d = '0;
            end else if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            data_out_q   <= '0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            data_out_q   <= data_out_d;
            dout_valid_q <= dout_valid_d;
            dout_last_q  <= dout_last_d;
        end
    end

    // Line memories are not reset; the row>=2 gate hides their initial contents.
    always_ff @(posedge clk) begin
        if (!rst && din_valid) begin
            line0_q[eff_col] <= rd_line1;
            line1_q[eff_col] <= din;
        end
    end

    assign data_out   = data_out_q;
    assign dout_valid = dout_valid_q;
    assign dout_last  = dout_last_q;

endmodule
